// File: rtl/uparc_muldiv_seq_pkg.sv
// rtl/uparc_muldiv_seq_pkg.sv - shared constants, op codes and state encoding for the mul/div sequencer
package uparc_muldiv_seq_pkg;

    localparam int UPARC_REG_WIDTH = 32;
    localparam int UPARC_MDOP_WIDTH = 2;

    localparam logic [UPARC_MDOP_WIDTH-1:0] UPARC_MDOP_MULT  = 2'd0;
    localparam logic [UPARC_MDOP_WIDTH-1:0] UPARC_MDOP_MULTU = 2'd1;
    localparam logic [UPARC_MDOP_WIDTH-1:0] UPARC_MDOP_DIV   = 2'd2;
    localparam logic [UPARC_MDOP_WIDTH-1:0] UPARC_MDOP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    // Op encoding: bit 1 selects divide, bit 0 selects unsigned.
    function automatic logic op_is_div(input logic [UPARC_MDOP_WIDTH-1:0] op_v);
        return op_v[1];
    endfunction

    function automatic logic op_is_signed(input logic [UPARC_MDOP_WIDTH-1:0] op_v);
        return ~op_v[0];
    endfunction

endpackage

// File: rtl/uparc_muldiv_neg.sv
// rtl/uparc_muldiv_neg.sv - conditional two's-complement negate of a W-bit value
module uparc_muldiv_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/uparc_muldiv_seq.sv
// rtl/uparc_muldiv_seq.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; optional UPARC_MULDIV_EARLY_EXIT_EN
module uparc_muldiv_seq
    import uparc_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = UPARC_REG_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [UPARC_MDOP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]            a,
    input  logic [WIDTH-1:0]            b,
    input  logic                        abort,
    input  logic                        hi_wr,
    input  logic                        lo_wr,
    input  logic [WIDTH-1:0]            wdata,
    output logic                        busy,
    output logic                        done,
    output logic                        div_zero,
    output logic [WIDTH-1:0]            hi,
    output logic [WIDTH-1:0]            lo
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_e                   state_q, state_d;
    logic [UPARC_MDOP_WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0]            acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]            acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]            dvs_q, dvs_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        negq_q, negq_d;
    logic                        negr_q, negr_d;
    logic                        dz_q, dz_d;
    logic                        done_q, done_d;
    logic                        div_zero_q, div_zero_d;
    logic [WIDTH-1:0]            hi_q, hi_d;
    logic [WIDTH-1:0]            lo_q, lo_d;

    logic             cap_signed;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign cap_signed = op_is_signed(op);

    uparc_muldiv_neg #(.W(WIDTH)) u_abs_a (
        .val_i (a),
        .neg_i (cap_signed & a[WIDTH-1]),
        .val_o (abs_a)
    );

    uparc_muldiv_neg #(.W(WIDTH)) u_abs_b (
        .val_i (b),
        .neg_i (cap_signed & b[WIDTH-1]),
        .val_o (abs_b)
    );

    // One shared adder: add mcand for multiply, subtract divisor from the shifted remainder for divide.
    logic             is_div;
    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic [WIDTH+1:0] add_s;

    assign is_div = op_is_div(op_q);
    assign add_x  = is_div ? {acc_hi_q, acc_lo_q[WIDTH-1]} : {1'b0, acc_hi_q};
    assign add_y  = is_div ? ~{1'b0, dvs_q} : {1'b0, dvs_q};
    assign add_s  = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, is_div};

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;
    logic             no_borrow;

    assign mul_sum   = acc_lo_q[0] ? add_s[WIDTH:0] : {1'b0, acc_hi_q};
    assign mul_hi    = mul_sum[WIDTH:1];
    assign mul_lo    = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    assign no_borrow = add_s[WIDTH+1];
    assign div_hi    = no_borrow ? add_s[WIDTH-1:0] : add_x[WIDTH-1:0];
    assign div_lo    = {acc_lo_q[WIDTH-2:0], no_borrow};

    logic [2*WIDTH-1:0] prod_raw, prod_n;
    logic [WIDTH-1:0]   quo_n, rem_n, fix_hi, fix_lo;

`ifdef UPARC_MULDIV_EARLY_EXIT_EN
    // Multiplier bits still waiting to be consumed after this iteration.
    logic [WIDTH-1:0] rem_mask;
    assign rem_mask = ~({WIDTH{1'b1}} << (cnt_q - 1'b1));
    assign prod_raw = {acc_hi_q, acc_lo_q} >> cnt_q;
`else
    assign prod_raw = {acc_hi_q, acc_lo_q};
`endif

    uparc_muldiv_neg #(.W(2*WIDTH)) u_neg_prod (
        .val_i (prod_raw),
        .neg_i ((op_q == UPARC_MDOP_MULT) & negq_q),
        .val_o (prod_n)
    );

    uparc_muldiv_neg #(.W(WIDTH)) u_neg_quo (
        .val_i (acc_lo_q),
        .neg_i ((op_q == UPARC_MDOP_DIV) & negq_q),
        .val_o (quo_n)
    );

    uparc_muldiv_neg #(.W(WIDTH)) u_neg_rem (
        .val_i (acc_hi_q),
        .neg_i ((op_q == UPARC_MDOP_DIV) & negr_q),
        .val_o (rem_n)
    );

    // A divide-by-zero preloads acc_hi=a and acc_lo=ones, which pass through untouched.
    assign fix_hi = dz_q ? acc_hi_q : (is_div ? rem_n : prod_n[2*WIDTH-1:WIDTH]);
    assign fix_lo = dz_q ? acc_lo_q : (is_div ? quo_n : prod_n[WIDTH-1:0]);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        dz_d       = dz_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    op_d       = op;
                    negq_d     = cap_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    negr_d     = cap_signed & a[WIDTH-1];
                    div_zero_d = 1'b0;
                    cnt_d      = CW'(WIDTH);
                    dvs_d      = op_is_div(op) ? abs_b : abs_a;
                    acc_hi_d   = '0;
                    acc_lo_d   = op_is_div(op) ? abs_a : abs_b;
                    dz_d       = op_is_div(op) && (b == '0);
                    state_d    = ST_CALC;
                    if (op_is_div(op) && (b == '0)) begin
                        acc_hi_d = a;
                        acc_lo_d = '1;
                        state_d  = ST_FIX;
                    end
`ifdef UPARC_MULDIV_EARLY_EXIT_EN
                    if (!op_is_div(op) && (abs_b == '0)) begin
                        state_d = ST_FIX;
                    end
`endif
                end else if (!start) begin
                    if (hi_wr) hi_d = wdata;
                    if (lo_wr) lo_d = wdata;
                end
            end
            ST_CALC: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_hi_d = is_div ? div_hi : mul_hi;
                    acc_lo_d = is_div ? div_lo : mul_lo;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_FIX;
                    end
`ifdef UPARC_MULDIV_EARLY_EXIT_EN
                    if (!is_div && ((mul_lo & rem_mask) == '0)) begin
                        state_d = ST_FIX;
                    end
`endif
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!abort) begin
                    hi_d       = fix_hi;
                    lo_d       = fix_lo;
                    done_d     = 1'b1;
                    div_zero_d = dz_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            dz_q       <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            negq_q     <= negq_d;
            negr_q     <= negr_d;
            dz_q       <= dz_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_uparc_muldiv_seq.sv
// tb/tb_uparc_muldiv_seq.sv - self-checking bench for uparc_muldiv_seq: vector table, random ops vs arithmetic model, corner sequences
module tb_uparc_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    uparc_muldiv_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .abort    (abort),
        .hi_wr    (hi_wr),
        .lo_wr    (lo_wr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: MIPS HI/LO results straight from 64-bit integer arithmetic.
    task automatic model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa  = longint'($signed(av));
        sb  = longint'($signed(bv));
        ua  = {32'd0, av};
        ub  = {32'd0, bv};
        rdz = 1'b0;
        p   = '0;
        if (o[1] && bv == 32'd0) begin
            rdz = 1'b1;
            rhi = av;
            rlo = 32'hFFFFFFFF;
        end else begin
            case (o)
                2'd0: p = 64'(sa * sb);
                2'd1: p = ua * ub;
                2'd2: p = {32'(sa % sb), 32'(sa / sb)};
                default: p = {32'(ua % ub), 32'(ua / ub)};
            endcase
            rhi = p[63:32];
            rlo = p[31:0];
        end
    endtask

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] bv);
        if (o[1] && bv == 32'd0) return 2;
`ifdef UPARC_MULDIV_EARLY_EXIT_EN
        if (!o[1]) begin
            logic [31:0] mb;
            int          hb;
            mb = (o == 2'd0 && bv[31]) ? -bv : bv;
            if (mb == 32'd0) return 2;
            hb = 0;
            for (int i = 0; i < 32; i++) if (mb[i]) hb = i;
            return hb + 3;
        end
`endif
        return 34;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        bcnt  = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic check_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                            input logic [31:0] bv, input logic [31:0] ehi,
                            input logic [31:0] elo, input logic edz);
        int lat;
        int bcnt;
        int el;
        run_op(o, av, bv, lat, bcnt);
        el = exp_lat(o, bv);
        check({tag, " latency"}, 64'(lat), 64'(el));
        check({tag, " busy_cycles"}, 64'(bcnt), 64'(el - 1));
        check({tag, " hi"}, {32'd0, hi}, {32'd0, ehi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, elo});
        check({tag, " div_zero"}, 64'(div_zero), 64'(edz));
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] mhi;
        logic [31:0] mlo;
        logic        mdz;
        logic        seen_done;
        int          sel;

        tbl[0] = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3] = '{2'd3, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
        tbl[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[5] = '{2'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
        tbl[6] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[7] = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};

        rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        abort = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            check_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                     tbl[i].hi, tbl[i].lo, tbl[i].dz);
        end

        for (int i = 0; i < 40; i++) begin
            ro  = 2'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 7));
            ra  = (sel == 7) ? 32'h80000000 : $urandom;
            case (sel)
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            model(ro, ra, rb, mhi, mlo, mdz);
            check_op($sformatf("rnd%0d", i), ro, ra, rb, mhi, mlo, mdz);
        end

        // MTLO/MTHI writes, then abort in CALC with ignored start and write.
        @(negedge clk);
        hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h0F0F0F0F;
        @(posedge clk); #1;
        hi_wr = 1'b0; lo_wr = 1'b0;
        @(negedge clk);
        check("both_wr hi", {32'd0, hi}, 64'h0F0F0F0F);
        check("both_wr lo", {32'd0, lo}, 64'h0F0F0F0F);
        hi_wr = 1'b1; wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        hi_wr = 1'b0;
        @(negedge clk);
        check("mthi hi", {32'd0, hi}, 64'hA5A5A5A5);
        check("mthi lo kept", {32'd0, lo}, 64'h0F0F0F0F);
        start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        seen_done = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            hi_wr = 1'b0; start = 1'b0; abort = 1'b0;
            if (c == 3) begin hi_wr = 1'b1; wdata = 32'h11111111; end
            if (c == 5) begin start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd0; end
            if (c == 9) check("abort busy_before", 64'(busy), 64'd1);
            if (c == 10) abort = 1'b1;
            if (c == 11) check("abort busy_after", 64'(busy), 64'd0);
        end
        check("abort no_done", 64'(seen_done), 64'd0);
        check("abort hi", {32'd0, hi}, 64'hA5A5A5A5);
        check("abort lo", {32'd0, lo}, 64'h0F0F0F0F);

        // abort together with start in IDLE starts nothing.
        start = 1'b1; abort = 1'b1; op = 2'd3; a = 32'd9; b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_start busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("abort_start done", 64'(done), 64'd0);

        // start with hi_wr: write dropped; divide-by-zero result then arrives.
        start = 1'b1; hi_wr = 1'b1; wdata = 32'hDEADBEEF; op = 2'd3; a = 32'h55; b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; hi_wr = 1'b0;
        @(negedge clk);
        check("start_wr hi_kept", {32'd0, hi}, 64'hA5A5A5A5);
        @(negedge clk);
        check("dz done", 64'(done), 64'd1);
        check("dz hi", {32'd0, hi}, 64'h55);
        repeat (5) @(negedge clk);
        check("dz hold", 64'(div_zero), 64'd1);
        start = 1'b1; op = 2'd1; a = 32'hFFFFFFFF; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("dz cleared", 64'(div_zero), 64'd0);
        seen_done = 1'b0;
        for (int c = 2; c <= 100 && !seen_done; c++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("multu2 done", 64'(seen_done), 64'd1);
        check("multu2 hi", {32'd0, hi}, 64'h2);

        // Asynchronous reset mid-CALC.
        start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst busy", 64'(busy), 64'd0);
        check("async_rst hi", {32'd0, hi}, 64'd0);
        check("async_rst lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check_op("post_rst", 2'd1, 32'd12, 32'd12, 32'd0, 32'd144, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
